task_answer_tx: RTL and testbench

//  Consumer end of a task wrapper's task_out interface: buffers 32-bit answer words (no backpressure, tready=1

---
 rtl/task_tx_pkg.sv | 26 ++
 rtl/answer_tx_fifo.sv | 52 +++++
 rtl/task_answer_tx.sv | 207 ++++++++++++++++++++
 tb/tb_task_answer_tx.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/task_tx_pkg.sv
// Shared types and constants for the answer framing transmitter.
package task_tx_pkg;

    // Frame sequencing states; StCsum exists only when the checksum byte is built in.
    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StHdr,
        StData,
`ifdef ANSWER_TX_CHECKSUM_EN
        StCsum,
`endif
        StDrain
    } tx_state_e;

    localparam int unsigned HDR_BYTES         = 9;
    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

    // Byte-lane index within an answer word (covers words up to 128 bits).
    localparam int unsigned LANE_IDX_W = 4;
    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

    // Header byte index (0..HDR_BYTES-1).
    typedef logic [3:0] hdr_idx_t;

endpackage

// File: rtl/answer_tx_fifo.sv
// Single-clock first-word-fall-through FIFO buffering answer words.
module answer_tx_fifo
    import task_tx_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2048
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Extra MSB distinguishes full from empty when the address bits match.
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    // Pointer update; writes and reads are ignored when full / empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en && !full) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en && !empty) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en && !full) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr_q[AW-1:0]];
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/task_answer_tx.sv
// Answer framing transmitter: buffers answer words, then emits
// SYNC, size (LE), latency (LE), payload bytes (LSB first) to the UART TX path.
// Optional trailing XOR checksum byte when ANSWER_TX_CHECKSUM_EN is defined.
module task_answer_tx
    import task_tx_pkg::*;
#(
    parameter int unsigned ANSWER_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH   = 2048,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_answer_valid,
    input  logic [ANSWER_WIDTH-1:0] i_answer_data,
    input  logic                    i_answer_last,
    input  logic [31:0]             i_answer_size_bytes,
    input  logic [31:0]             i_answer_latency,
    output logic [7:0]              o_tx_data,
    output logic                    o_tx_valid,
    input  logic                    i_tx_ready,
    output logic                    o_busy,
    output logic                    o_overflow,
    output logic                    o_underrun
);

    localparam int unsigned LANES = ANSWER_WIDTH / 8;

`ifdef ANSWER_TX_CHECKSUM_EN
    localparam tx_state_e AFTER_DATA = StCsum;
`else
    localparam tx_state_e AFTER_DATA = StDrain;
`endif

    tx_state_e   state_q, state_d;
    hdr_idx_t    hdr_idx_q, hdr_idx_d;
    lane_idx_t   lane_q, lane_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] size_q, size_d;
    logic [31:0] lat_q, lat_d;
    logic [7:0]  csum_q, csum_d;
    logic        overflow_q, overflow_d;
    logic        underrun_q, underrun_d;

    logic                    fifo_wr;
    logic                    fifo_rd;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [ANSWER_WIDTH-1:0] fifo_head;

    logic [7:0] hdr_bytes [HDR_BYTES];
    logic [7:0] payload_byte;
    logic [7:0] tx_data;
    logic       tx_valid;

    answer_tx_fifo #(
        .WIDTH (ANSWER_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst     (i_rst),
        .wr_en   (fifo_wr),
        .wr_data (i_answer_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Header byte table built from the latched size and latency.
    always_comb begin
        hdr_bytes[0] = SYNC_BYTE;
        for (int i = 0; i < 4; i++) begin
            hdr_bytes[1 + i] = size_q[8*i +: 8];
            hdr_bytes[5 + i] = lat_q[8*i +: 8];
        end
    end

    // Missing words are sent as zero rather than stalling the stream.
    assign payload_byte = fifo_empty ? 8'h00 : fifo_head[8*int'(lane_q) +: 8];

    // Next-state, FIFO control and byte output selection.
    always_comb begin
        state_d    = state_q;
        hdr_idx_d  = hdr_idx_q;
        lane_d     = lane_q;
        cnt_d      = cnt_q;
        size_d     = size_q;
        lat_d      = lat_q;
        csum_d     = csum_q;
        overflow_d = overflow_q;
        underrun_d = underrun_q;
        fifo_wr    = 1'b0;
        fifo_rd    = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;

        unique case (state_q)
            StIdle: begin
                if (i_answer_valid) begin
                    if (fifo_full) begin
                        overflow_d = 1'b1;
                    end else begin
                        fifo_wr = 1'b1;
                    end
                    if (i_answer_last) begin
                        state_d = StLatch;
                    end
                end
            end
            StLatch: begin
                size_d    = i_answer_size_bytes;
                lat_d     = i_answer_latency;
                cnt_d     = i_answer_size_bytes;
                hdr_idx_d = '0;
                lane_d    = '0;
                csum_d    = 8'h00;
                state_d   = StHdr;
            end
            StHdr: begin
                tx_valid = 1'b1;
                tx_data  = hdr_bytes[hdr_idx_q];
                if (i_tx_ready) begin
                    csum_d    = csum_q ^ tx_data;
                    hdr_idx_d = hdr_idx_q + 1'b1;
                    if (hdr_idx_q == hdr_idx_t'(HDR_BYTES - 1)) begin
                        state_d = (cnt_q == 32'd0) ? AFTER_DATA : StData;
                    end
                end
            end
            StData: begin
                tx_valid = 1'b1;
                tx_data  = payload_byte;
                if (i_tx_ready) begin
                    csum_d = csum_q ^ tx_data;
                    cnt_d  = cnt_q - 32'd1;
                    if (fifo_empty) begin
                        underrun_d = 1'b1;
                    end
                    // Retire the head word after its last lane or the final payload byte.
                    if (lane_q == lane_idx_t'(LANES - 1) || cnt_q == 32'd1) begin
                        lane_d  = '0;
                        fifo_rd = !fifo_empty;
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                    if (cnt_q == 32'd1) begin
                        state_d = AFTER_DATA;
                    end
                end
            end
`ifdef ANSWER_TX_CHECKSUM_EN
            StCsum: begin
                tx_valid = 1'b1;
                tx_data  = csum_q;
                if (i_tx_ready) begin
                    state_d = StDrain;
                end
            end
`endif
            StDrain: begin
                if (fifo_empty) begin
                    state_d = StIdle;
                end else begin
                    fifo_rd = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // The frame in flight owns the FIFO; any new word is lost.
        if (state_q != StIdle && i_answer_valid) begin
            overflow_d = 1'b1;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            hdr_idx_q  <= '0;
            lane_q     <= '0;
            cnt_q      <= '0;
            size_q     <= '0;
            lat_q      <= '0;
            csum_q     <= '0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_idx_q  <= hdr_idx_d;
            lane_q     <= lane_d;
            cnt_q      <= cnt_d;
            size_q     <= size_d;
            lat_q      <= lat_d;
            csum_q     <= csum_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
        end
    end

    assign o_tx_data  = tx_data;
    assign o_tx_valid = tx_valid;
    assign o_busy     = (state_q != StIdle);
    assign o_overflow = overflow_q;
    assign o_underrun = underrun_q;

endmodule

// File: tb/tb_task_answer_tx.sv
// Directed self-checking bench for task_answer_tx (checksum byte expected
// when ANSWER_TX_CHECKSUM_EN is defined).
module tb_task_answer_tx;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_answer_valid;
    logic [31:0] i_answer_data;
    logic        i_answer_last;
    logic [31:0] i_answer_size_bytes;
    logic [31:0] i_answer_latency;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic        o_busy;
    logic        o_overflow;
    logic        o_underrun;

    int n_tests = 0;
    int n_fail  = 0;

    // Ready generation: fixed level or ~30% random.
    logic rand_ready  = 1'b0;
    logic ready_level = 1'b1;

    // Captured byte stream and stall-stability monitor state.
    logic [7:0] got [0:511];
    int         got_n       = 0;
    int         stable_viol = 0;
    logic       prev_v      = 1'b0;
    logic       prev_r      = 1'b0;
    logic       prev_rst    = 1'b1;
    logic [7:0] prev_d      = 8'h00;

    logic [7:0] exp_b [0:63];
    int         exp_n;

    task_answer_tx #(
        .ANSWER_WIDTH (32),
        .FIFO_DEPTH   (64),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_answer_valid      (i_answer_valid),
        .i_answer_data       (i_answer_data),
        .i_answer_last       (i_answer_last),
        .i_answer_size_bytes (i_answer_size_bytes),
        .i_answer_latency    (i_answer_latency),
        .o_tx_data           (o_tx_data),
        .o_tx_valid          (o_tx_valid),
        .i_tx_ready          (i_tx_ready),
        .o_busy              (o_busy),
        .o_overflow          (o_overflow),
        .o_underrun          (o_underrun)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        i_tx_ready <= rand_ready ? ($urandom_range(0, 9) < 3) : ready_level;
    end

    // Record each byte that will be accepted at the next edge; flag stalled-byte changes.
    always @(negedge i_clk) begin
        if (o_tx_valid && i_tx_ready && got_n < 512) begin
            got[got_n] <= o_tx_data;
            got_n      <= got_n + 1;
        end
        if (prev_v && !prev_r && !prev_rst && (!o_tx_valid || o_tx_data !== prev_d)) begin
            stable_viol <= stable_viol + 1;
        end
        prev_v   <= o_tx_valid;
        prev_r   <= i_tx_ready;
        prev_d   <= o_tx_data;
        prev_rst <= i_rst;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] d, input logic l);
        i_answer_valid = 1'b1;
        i_answer_data  = d;
        i_answer_last  = l;
        @(posedge i_clk);
        #1;
        i_answer_valid = 1'b0;
        i_answer_last  = 1'b0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000 && o_busy; i++) begin
            @(posedge i_clk);
            #1;
        end
        check({tag, "_idle"}, o_busy, 1'b0);
    endtask

    // Expected frame: header, payload (zero past the supplied words), optional checksum.
    task automatic build_exp(input logic [31:0] size, input logic [31:0] lat,
                             input int nwords, input logic [31:0] w0, input logic [31:0] w1);
        logic [31:0] w;
        logic [7:0]  x;
        exp_b[0] = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            exp_b[1 + i] = size[8*i +: 8];
            exp_b[5 + i] = lat[8*i +: 8];
        end
        for (int k = 0; k < int'(size); k++) begin
            w = (k / 4 == 0) ? w0 : w1;
            exp_b[9 + k] = (k / 4 < nwords) ? w[8*(k % 4) +: 8] : 8'h00;
        end
        exp_n = 9 + int'(size);
`ifdef ANSWER_TX_CHECKSUM_EN
        x = 8'h00;
        for (int k = 0; k < exp_n; k++) x = x ^ exp_b[k];
        exp_b[exp_n] = x;
        exp_n++;
`else
        x = 8'h00;
`endif
    endtask

    task automatic check_frame(input string tag, input int st);
        check({tag, "_len"}, 32'(got_n - st), 32'(exp_n));
        for (int i = 0; i < exp_n; i++) begin
            check($sformatf("%s_b%0d", tag, i), {24'h0, got[(st + i) % 512]}, {24'h0, exp_b[i]});
        end
    endtask

    initial begin
        int st;
        i_rst               = 1'b1;
        i_answer_valid      = 1'b0;
        i_answer_data       = '0;
        i_answer_last       = 1'b0;
        i_answer_size_bytes = '0;
        i_answer_latency    = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_valid", o_tx_valid, 1'b0);
        check("rst_data", o_tx_data, 8'h00);
        check("rst_busy", o_busy, 1'b0);
        check("rst_overflow", o_overflow, 1'b0);
        check("rst_underrun", o_underrun, 1'b0);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        // Test 1: two words, size 8, first valid at N+2.
        st = got_n;
        i_answer_size_bytes = 32'd8;
        i_answer_latency    = 32'h10;
        push_word(32'h44332211, 1'b0);
        push_word(32'h88776655, 1'b1);
        check("t1_latch_valid", o_tx_valid, 1'b0);
        check("t1_latch_busy", o_busy, 1'b1);
        @(posedge i_clk);
        #1;
        check("t1_n2_valid", o_tx_valid, 1'b1);
        check("t1_n2_sync", o_tx_data, 8'hA5);
        wait_idle("t1");
        build_exp(32'd8, 32'h10, 2, 32'h44332211, 32'h88776655);
        check_frame("t1", st);
        check("t1_underrun", o_underrun, 1'b0);
        check("t1_overflow", o_overflow, 1'b0);

        // Test 2: size 6 suppresses the top two bytes of the last word.
        st = got_n;
        i_answer_size_bytes = 32'd6;
        push_word(32'h44332211, 1'b0);
        push_word(32'h88776655, 1'b1);
        wait_idle("t2");
        build_exp(32'd6, 32'h10, 2, 32'h44332211, 32'h88776655);
        check_frame("t2", st);

        // Test 3: random ready; FIFO must also be empty after test 2.
        st = got_n;
        rand_ready = 1'b1;
        i_answer_size_bytes = 32'd8;
        push_word(32'h44332211, 1'b0);
        push_word(32'h88776655, 1'b1);
        wait_idle("t3");
        rand_ready = 1'b0;
        build_exp(32'd8, 32'h10, 2, 32'h44332211, 32'h88776655);
        check_frame("t3", st);
        check("t3_stable", 32'(stable_viol), 32'd0);
        check("t3_underrun", o_underrun, 1'b0);

        // Test 4a: one word, size 12 -> eight zero bytes and underrun.
        repeat (2) @(posedge i_clk);
        #1;
        st = got_n;
        i_answer_size_bytes = 32'd12;
        push_word(32'h44332211, 1'b1);
        wait_idle("t4u");
        build_exp(32'd12, 32'h10, 1, 32'h44332211, 32'h0);
        check_frame("t4u", st);
        check("t4u_underrun", o_underrun, 1'b1);

        // Test 4b: FIFO_DEPTH+1 words -> overflow; excess words drained.
        do_reset();
        check("t4o_underrun_clr", o_underrun, 1'b0);
        st = got_n;
        i_answer_size_bytes = 32'd4;
        for (int i = 0; i < 64; i++) push_word(32'h03020100 + 32'(i) * 32'h04040404, 1'b0);
        check("t4o_not_yet", o_overflow, 1'b0);
        push_word(32'hFFFFFFFF, 1'b1);
        check("t4o_overflow", o_overflow, 1'b1);
        wait_idle("t4o");
        build_exp(32'd4, 32'h10, 1, 32'h03020100, 32'h0);
        check_frame("t4o", st);
        check("t4o_sticky", o_overflow, 1'b1);

        // Test 5: word during HDR dropped; reset in DATA abandons the frame.
        do_reset();
        ready_level = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        st = got_n;
        i_answer_size_bytes = 32'd8;
        push_word(32'h44332211, 1'b0);
        push_word(32'h88776655, 1'b1);
        @(posedge i_clk);
        #1;
        push_word(32'hDEADBEEF, 1'b0);
        check("t5_overflow", o_overflow, 1'b1);
        check("t5_stall_data", o_tx_data, 8'hA5);
        check("t5_stall_valid", o_tx_valid, 1'b1);
        ready_level = 1'b1;
        for (int i = 0; i < 100 && (got_n - st) < 10; i++) begin
            @(negedge i_clk);
            #1;
        end
        check("t5_reach_data", 32'(got_n - st >= 10), 32'd1);
        check("t5_first_payload", {24'h0, got[(st + 9) % 512]}, 32'h11);
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        check("t5_rst_valid", o_tx_valid, 1'b0);
        check("t5_rst_busy", o_busy, 1'b0);
        check("t5_rst_overflow", o_overflow, 1'b0);
        check("t5_rst_data", o_tx_data, 8'h00);

        // Test 6: full frame after mid-frame reset (checksum when enabled).
        @(posedge i_clk);
        #1;
        st = got_n;
        i_answer_size_bytes = 32'd8;
        push_word(32'h44332211, 1'b0);
        push_word(32'h88776655, 1'b1);
        wait_idle("t6");
        build_exp(32'd8, 32'h10, 2, 32'h44332211, 32'h88776655);
        check_frame("t6", st);
        check("t6_stable", 32'(stable_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
